// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DMEM_WAIT = 2'd1,
        ST_HALT      = 2'd2
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources read in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic       i_ex_valid,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd_addr,
    output logic       o_load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
    assign rs2_hit    = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
    // x0 is never written, so a load targeting it cannot create a hazard
    assign o_load_use = i_ex_valid & i_ex_mem_read & (i_ex_rd_addr != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with saturating stall counter.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_redirect,
    input  logic             i_imem_ready,
    input  logic             i_mem_valid,
    input  logic             i_mem_access,
    input  logic             i_dmem_ready,
    input  logic             i_wb_valid,
    input  logic             i_wb_halt,
    output logic             o_pc_en,
    output logic             o_pc_redirect,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_ex_mem_flush,
    output logic             o_mem_wb_en,
    output logic             o_mem_wb_flush,
    output logic             o_dmem_req,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cycles
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;
    logic             mem_busy;

    hazard_detect u_hazard_detect (
        .i_id_rs1_addr (i_id_rs1_addr),
        .i_id_rs2_addr (i_id_rs2_addr),
        .i_id_rs1_used (i_id_rs1_used),
        .i_id_rs2_used (i_id_rs2_used),
        .i_ex_valid    (i_ex_valid),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd_addr  (i_ex_rd_addr),
        .o_load_use    (load_use)
    );

    assign mem_busy = i_mem_valid & i_mem_access;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        o_pc_en        = 1'b1;
        o_pc_redirect  = 1'b0;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_en    = 1'b1;
        o_ex_mem_flush = 1'b0;
        o_mem_wb_en    = 1'b1;
        o_mem_wb_flush = 1'b0;
        o_dmem_req     = 1'b0;

        if (i_rst) begin
            state_d        = ST_RUN;
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
            o_mem_wb_flush = 1'b1;
        end else if (state_q == ST_HALT || (i_wb_valid & i_wb_halt)) begin
            // Retiring halt abandons any outstanding data access
            state_d     = ST_HALT;
            o_pc_en     = 1'b0;
            o_if_id_en  = 1'b0;
            o_id_ex_en  = 1'b0;
            o_ex_mem_en = 1'b0;
            o_mem_wb_en = 1'b0;
        end else begin
            o_dmem_req = mem_busy;
            if (mem_busy & ~i_dmem_ready) begin
                // EX is frozen, so a pending redirect is seen again on release
                state_d        = ST_DMEM_WAIT;
                o_pc_en        = 1'b0;
                o_if_id_en     = 1'b0;
                o_id_ex_en     = 1'b0;
                o_ex_mem_en    = 1'b0;
                o_mem_wb_flush = 1'b1;
            end else begin
                state_d = ST_RUN;
                if (i_ex_redirect) begin
                    o_pc_redirect = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                end else if (load_use) begin
                    o_pc_en       = 1'b0;
                    o_if_id_en    = 1'b0;
                    o_id_ex_flush = 1'b1;
                end else if (~i_imem_ready) begin
                    o_pc_en       = 1'b0;
                    o_if_id_flush = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (~o_pc_en && state_q != ST_HALT && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_halted       = (state_q == ST_HALT) & ~i_rst;
    assign o_stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected output vectors are queued per cycle.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rs1_used, rs2_used;
    logic        ex_valid, ex_mem_read, ex_redirect, imem_ready;
    logic        mem_valid, mem_access, dmem_ready, wb_valid, wb_halt;
    logic        pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, dmem_req, halted;
    logic [31:0] stall_cycles;
    logic        n_pc_en, n_pc_redirect, n_if_id_en, n_if_id_flush, n_id_ex_en, n_id_ex_flush;
    logic        n_ex_mem_en, n_ex_mem_flush, n_mem_wb_en, n_mem_wb_flush, n_dmem_req, n_halted;
    logic [3:0]  stall_cycles4;

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    // {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //  ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, dmem_req, halted}
    localparam logic [11:0] V_RUN      = 12'b1010_1010_1000;
    localparam logic [11:0] V_RESET    = 12'b0001_0101_0100;
    localparam logic [11:0] V_LOADUSE  = 12'b0000_1110_1000;
    localparam logic [11:0] V_REDIRECT = 12'b1111_1110_1000;
    localparam logic [11:0] V_FETCH    = 12'b0011_1010_1000;
    localparam logic [11:0] V_DSTALL   = 12'b0000_0000_1110;
    localparam logic [11:0] V_DGO      = 12'b1010_1010_1010;
    localparam logic [11:0] V_HALTING  = 12'b0000_0000_0000;
    localparam logic [11:0] V_HALTED   = 12'b0000_0000_0001;

    pipeline_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1_addr(rs1_addr), .i_id_rs2_addr(rs2_addr),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rd_addr(rd_addr),
        .i_ex_redirect(ex_redirect), .i_imem_ready(imem_ready),
        .i_mem_valid(mem_valid), .i_mem_access(mem_access), .i_dmem_ready(dmem_ready),
        .i_wb_valid(wb_valid), .i_wb_halt(wb_halt),
        .o_pc_en(pc_en), .o_pc_redirect(pc_redirect),
        .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
        .o_id_ex_en(id_ex_en), .o_id_ex_flush(id_ex_flush),
        .o_ex_mem_en(ex_mem_en), .o_ex_mem_flush(ex_mem_flush),
        .o_mem_wb_en(mem_wb_en), .o_mem_wb_flush(mem_wb_flush),
        .o_dmem_req(dmem_req), .o_halted(halted), .o_stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1_addr(rs1_addr), .i_id_rs2_addr(rs2_addr),
        .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_ex_valid(ex_valid), .i_ex_mem_read(ex_mem_read), .i_ex_rd_addr(rd_addr),
        .i_ex_redirect(ex_redirect), .i_imem_ready(imem_ready),
        .i_mem_valid(mem_valid), .i_mem_access(mem_access), .i_dmem_ready(dmem_ready),
        .i_wb_valid(wb_valid), .i_wb_halt(wb_halt),
        .o_pc_en(n_pc_en), .o_pc_redirect(n_pc_redirect),
        .o_if_id_en(n_if_id_en), .o_if_id_flush(n_if_id_flush),
        .o_id_ex_en(n_id_ex_en), .o_id_ex_flush(n_id_ex_flush),
        .o_ex_mem_en(n_ex_mem_en), .o_ex_mem_flush(n_ex_mem_flush),
        .o_mem_wb_en(n_mem_wb_en), .o_mem_wb_flush(n_mem_wb_flush),
        .o_dmem_req(n_dmem_req), .o_halted(n_halted), .o_stall_cycles(stall_cycles4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; rd_addr = 5'd0; ex_redirect = 1'b0;
        imem_ready = 1'b1; mem_valid = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
        wb_valid = 1'b0; wb_halt = 1'b0;
    endtask

    // Queue the expectation for the cycle just driven, compare at negedge, advance past the edge.
    task automatic cyc(input string name, input logic [11:0] expv);
        logic [11:0] got, want;
        exp_q.push_back(expv);
        @(negedge clk);
        got = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, dmem_req, halted};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: outputs got %b want %b", name, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc("reset_outputs", V_RESET);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_counter: got %0d want 0", stall_cycles);
        end
        cyc("reset_idle_run", V_RUN);
    endtask

    task automatic test_load_use();
        do_reset();
        ex_valid = 1'b1; ex_mem_read = 1'b1; rd_addr = 5'd5;
        rs1_addr = 5'd5; rs1_used = 1'b1;
        cyc("load_use_rs1", V_LOADUSE);
        ex_valid = 1'b0;
        cyc("load_use_bubble", V_RUN);
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL load_use_counter: got %0d want 1", stall_cycles);
        end
        ex_valid = 1'b1; rs1_used = 1'b0; rs2_addr = 5'd5; rs2_used = 1'b1;
        cyc("load_use_rs2", V_LOADUSE);
        rs2_used = 1'b0; rs1_used = 1'b1;
        rd_addr = 5'd0; rs1_addr = 5'd0;
        cyc("load_use_x0", V_RUN);
        rd_addr = 5'd7; rs1_addr = 5'd7; rs1_used = 1'b0;
        cyc("load_use_unused_src", V_RUN);
        rs1_used = 1'b1; ex_mem_read = 1'b0;
        cyc("load_use_not_load", V_RUN);
        idle_inputs();
    endtask

    task automatic test_redirect_priority();
        do_reset();
        ex_valid = 1'b1; ex_mem_read = 1'b1; rd_addr = 5'd9;
        rs1_addr = 5'd9; rs1_used = 1'b1; ex_redirect = 1'b1;
        cyc("redirect_with_load_use", V_REDIRECT);
        idle_inputs();
        ex_redirect = 1'b1; imem_ready = 1'b0;
        cyc("redirect_with_fetch_wait", V_REDIRECT);
        ex_redirect = 1'b0;
        cyc("fetch_wait", V_FETCH);
        idle_inputs();
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++;
            $display("FAIL redirect_counter: got %0d want 1", stall_cycles);
        end
    endtask

    task automatic test_dmem_wait();
        do_reset();
        mem_valid = 1'b1; mem_access = 1'b1; dmem_ready = 1'b0;
        cyc("dmem_stall_1", V_DSTALL);
        ex_redirect = 1'b1;
        cyc("dmem_stall_2_redirect_ignored", V_DSTALL);
        ex_redirect = 1'b0;
        cyc("dmem_stall_3", V_DSTALL);
        dmem_ready = 1'b1;
        cyc("dmem_release", V_DGO);
        idle_inputs();
        cyc("dmem_back_to_run", V_RUN);
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL dmem_counter: got %0d want 3", stall_cycles);
        end
        mem_valid = 1'b1; mem_access = 1'b1; dmem_ready = 1'b1;
        cyc("dmem_zero_wait", V_DGO);
        idle_inputs();
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL dmem_zero_wait_counter: got %0d want 3", stall_cycles);
        end
    endtask

    task automatic test_halt_mid_wait();
        do_reset();
        mem_valid = 1'b1; mem_access = 1'b1; dmem_ready = 1'b0;
        cyc("halt_enter_wait", V_DSTALL);
        cyc("halt_wait_1", V_DSTALL);
        wb_valid = 1'b1; wb_halt = 1'b1;
        cyc("halt_wait_2_abandon", V_HALTING);
        for (int i = 0; i < 10; i++) begin
            {rs1_addr, rs2_addr, rd_addr} = 15'($urandom);
            {rs1_used, rs2_used, ex_valid, ex_mem_read, ex_redirect, imem_ready,
             mem_valid, mem_access, dmem_ready, wb_valid, wb_halt} = 11'($urandom);
            cyc("halted_frozen", V_HALTED);
        end
        idle_inputs();
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL halt_counter: got %0d want 3", stall_cycles);
        end
    endtask

    task automatic test_reset_in_dmem_wait();
        do_reset();
        mem_valid = 1'b1; mem_access = 1'b1; dmem_ready = 1'b0;
        cyc("rst_wait_enter", V_DSTALL);
        rst = 1'b1;
        cyc("rst_during_wait", V_RESET);
        idle_inputs();
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL rst_wait_counter: got %0d want 0", stall_cycles);
        end
        cyc("rst_wait_after_run", V_RUN);
        mem_valid = 1'b1; mem_access = 1'b1; dmem_ready = 1'b1;
        cyc("rst_wait_access_ok", V_DGO);
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc("sat_fetch_wait", V_FETCH);
            if (i == 13) begin
                checks++;
                if (stall_cycles4 !== 4'hE) begin
                    errors++;
                    $display("FAIL sat_cnt4_14: got %h want e", stall_cycles4);
                end
            end
            if (i == 14) begin
                checks++;
                if (stall_cycles4 !== 4'hF) begin
                    errors++;
                    $display("FAIL sat_cnt4_15: got %h want f", stall_cycles4);
                end
            end
        end
        idle_inputs();
        checks++;
        if (stall_cycles4 !== 4'hF) begin
            errors++;
            $display("FAIL sat_cnt4_hold: got %h want f", stall_cycles4);
        end
        checks++;
        if (stall_cycles !== 32'd20) begin
            errors++;
            $display("FAIL sat_cnt32: got %0d want 20", stall_cycles);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_redirect_priority();
        test_dmem_wait();
        test_halt_mid_wait();
        test_reset_in_dmem_wait();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it drives a load-enable and a flush (bubble-insert) for every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and for the PC. It covers load-use hazards, taken-branch redirects, instruction-fetch wait and multi-cycle data-memory handshakes, and it drains to a terminal halt state. It also keeps a saturating stall-cycle counter for performance readout.

## Interface
- `CNT_W`, default 32: width of stall-cycle counter.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_id_rs1_addr`, `i_id_rs2_addr` in 5 each: source registers of the instruction in ID.
- `i_id_rs1_used`, `i_id_rs2_used` in 1 each: source actually read.
- `i_ex_valid`, `i_ex_mem_read` in 1 each: EX holds a valid load.
- `i_ex_rd_addr` in 5: EX destination.
- `i_ex_redirect` in 1: valid taken branch/jump resolved in EX.
- `i_imem_ready` in 1: fetch data valid this cycle.
- `i_mem_valid`, `i_mem_access` in 1 each: MEM holds a valid load/store.
- `i_dmem_ready` in 1: data memory completes the access this cycle.
- `i_wb_valid`, `i_wb_halt` in 1 each: a valid halt is retiring in WB.
- `o_pc_en`, `o_pc_redirect` out 1 each: PC load enable; select redirect target.
- `o_if_id_en`, `o_if_id_flush`, `o_id_ex_en`, `o_id_ex_flush`, `o_ex_mem_en`, `o_ex_mem_flush`, `o_mem_wb_en`, `o_mem_wb_flush` out 1 each.
- `o_dmem_req` out 1: data-memory request, level, held until ready.
- `o_halted` out 1: pipeline stopped.
- `o_stall_cycles` out `CNT_W`: cycles with `o_pc_en`=0 outside HALT.

## Operation
- Flush = register loads a bubble (valid, reg_write, mem_read, halt cleared) on next edge. Flush overrides enable at the register.
- States:
  - **RUN**. In RUN, enables are 1 and flushes are 0 unless a rule below applies.
  - **DMEM_WAIT**.
  - **HALT**.
- Priority, highest first:
  1. **Halt.** `i_wb_valid & i_wb_halt` → next state HALT, in any state. That cycle all enables are 0, and `o_dmem_req`=0 (an outstanding access is abandoned).
  2. **Data-memory stall.** Condition: `i_mem_valid & i_mem_access & ~i_dmem_ready`, in RUN or DMEM_WAIT.
     - `o_dmem_req`=1.
     - PC, IF/ID, ID/EX and EX/MEM enables are 0.
     - `o_mem_wb_flush`=1.
     - Next state DMEM_WAIT.
     - Any pending redirect is ignored; it is re-evaluated on release because EX is frozen.
  3. **Redirect.** `i_ex_redirect` → `o_pc_redirect`=1, `o_if_id_flush`=1, `o_id_ex_flush`=1. The PC is enabled even if a load-use or fetch stall is also present.
  4. **Load-use.** Condition: `i_ex_valid & i_ex_mem_read & i_ex_rd_addr≠0`, and the EX destination matches a used ID source. Response: `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_flush`=1.
  5. **Fetch wait.** `~i_imem_ready` → `o_pc_en`=0, `o_if_id_flush`=1. Downstream stages advance.
- `o_dmem_req`=1 whenever `i_mem_valid & i_mem_access` and state≠HALT, including the first cycle. With `i_dmem_ready`=1 in that same cycle there is zero stall and no state change.
- **DMEM_WAIT → RUN** on the cycle `i_dmem_ready`=1. In that cycle the enables follow RUN rules.
- **HALT** is terminal until reset:
  - all enables are 0;
  - all flushes are 0;
  - `o_halted`=1;
  - `o_dmem_req`=0.
- **Counter.** Increments by 1 on every edge where `o_pc_en`=0, state≠HALT and not in reset. It saturates at all-ones and never wraps.

## Timing
- All control outputs are combinational from state and inputs; there is no added latency.
- State, `o_halted` and the counter are registered.
- **While `i_rst`=1:**
  - enables are 0;
  - all flushes are 1;
  - `o_pc_redirect`=0;
  - `o_dmem_req`=0;
  - `o_halted`=0.
- **At the edge with `i_rst`=1:** state becomes RUN and the counter becomes 0.
- **Reset during DMEM_WAIT:** `o_dmem_req` drops in the same cycle, and the state is RUN after the edge.
- A load-use stall lasts exactly 1 cycle: the bubble reaches EX, which clears the hazard.
- **Redirect in the same cycle as `~i_imem_ready`:** `o_pc_en`=1 with redirect, so the target is fetched next.

## Structure
- Package `pipe_ctrl_pkg`:
  - state encoding (RUN=2'd0, DMEM_WAIT=2'd1, HALT=2'd2);
  - `CNT_W` default.
- Sub-module `hazard_detect`: purely combinational load-use compare; output `o_load_use`.
- FSM, priority logic and saturating counter stay in `pipeline_ctrl`, in an estimated 150–250 lines.

## Test plan
- **Load-use.** EX load, rd=x5; ID uses rs1=x5 → one cycle with `o_pc_en`=0, `o_if_id_en`=0, `o_id_ex_flush`=1. Next cycle all enables are 1. Counter=1. Repeat with rd=x0 → no stall.
- **Redirect plus load-use, same cycle.** `o_pc_redirect`=1, `o_pc_en`=1, IF/ID and ID/EX flushed.
- **Data-memory wait.** MEM store with `i_dmem_ready` low for 3 cycles → `o_dmem_req` high 4 cycles and upstream frozen 3 cycles. `o_mem_wb_flush` is 1 for 3 cycles and the state returns to RUN. Counter=3. With ready=1 in the first cycle → 0 stall cycles.
- **Halt mid-wait.** `i_wb_halt` in the 2nd DMEM_WAIT cycle → `o_dmem_req`=0 in that cycle. `o_halted`=1 from the next cycle, and all enables stay 0 for 10 cycles regardless of inputs.
- **Reset during DMEM_WAIT.** `o_dmem_req` is 0 that cycle and all flushes are 1. After reset: RUN, counter 0, `o_halted` 0.
- **Counter saturation.** `CNT_W`=4 with a 20-cycle fetch stall → `o_stall_cycles` holds 4'hF.
